// File: rtl/mips_rf_pkg.sv
// Shared constants for the register-file writeback path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Writeback requester indices on the arbiter
    localparam int WB_ALU    = 0;
    localparam int WB_LOAD   = 1;
    localparam int WB_MULDIV = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, cyclically.
// Latency: purely combinational.
// Backpressure: a request without grant simply waits; at most one grant bit is high.
// Ports: req_i (request vector), ptr_i (priority pointer), gnt_o (one-hot), gnt_idx_o (encoded grant).
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic found;

    // Two passes instead of modular index arithmetic: first look at indices
    // at or above the pointer, then wrap around to the low indices.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (IW'(i) >= ptr_i)) begin
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IW'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IW'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register bank write port among N_REQ writeback sources and tracks pending writes for RAW stalls.
// Latency: 1 cycle from handshake to regWriteFlag/wAddr/wrData; sustains one write per cycle.
// Backpressure: req_ready is a combinational one-hot round-robin grant; losers hold valid until granted.
// Ports: req_valid/req_addr/req_data/req_ready (requesters), wAddr/wrData/regWriteFlag (bank),
//        issue_valid/issue_addr (decode producer), rs_addr/rt_addr -> rs_busy/rt_busy, err_wb (sticky error).
module regfile_wb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = mips_rf_pkg::ADDR_W,
    parameter int DATA_W = mips_rf_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]       wAddr,
    output logic [DATA_W-1:0]       wrData,
    output logic                    regWriteFlag,
    input  logic                    issue_valid,
    input  logic [ADDR_W-1:0]       issue_addr,
    input  logic [ADDR_W-1:0]       rs_addr,
    input  logic [ADDR_W-1:0]       rt_addr,
    output logic                    rs_busy,
    output logic                    rt_busy,
    output logic                    err_wb
);

    import mips_rf_pkg::*;

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              hs;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wflag_q, wflag_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              err_q, err_d;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // No grants may escape while the block is held in reset.
    assign req_ready = rst_n ? gnt : '0;
    assign hs        = |(req_valid & req_ready);

    // One-hot grant selects the winner's address/data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wflag_d   = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        pending_d = pending_q;
        err_d     = err_q;
        if (hs) begin
            rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
            waddr_d  = sel_addr;
            wdata_d  = sel_data;
            wflag_d  = (sel_addr != ZERO_A);
            if (sel_addr != ZERO_A) begin
                pending_d[sel_addr] = 1'b0;
                if (!pending_q[sel_addr]) begin
                    err_d = 1'b1;
                end
            end
        end
        // Set after clear: a newly issued producer to the same register
        // keeps it busy even as the older value lands.
        if (issue_valid && (issue_addr != ZERO_A)) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wflag_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wflag_q   <= wflag_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign regWriteFlag = wflag_q;
    assign wAddr        = waddr_q;
    assign wrData       = wdata_q;
    assign err_wb       = err_q;
    assign rs_busy      = pending_q[rs_addr];
    assign rt_busy      = pending_q[rt_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table of per-cycle vectors with hand-derived expectations.
// Latency: expected writeback records are queued when a row is driven and popped one edge later.
// Backpressure: requesters hold valid/addr/data until their ready is observed.
module tb_regfile_wb_arbiter;

    import mips_rf_pkg::*;

    localparam int N_REQ = 3;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]       wAddr;
    logic [DATA_W-1:0]       wrData;
    logic                    regWriteFlag;
    logic                    issue_valid;
    logic [ADDR_W-1:0]       issue_addr;
    logic [ADDR_W-1:0]       rs_addr;
    logic [ADDR_W-1:0]       rt_addr;
    logic                    rs_busy;
    logic                    rt_busy;
    logic                    err_wb;

    regfile_wb_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wAddr        (wAddr),
        .wrData       (wrData),
        .regWriteFlag (regWriteFlag),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .err_wb       (err_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        iv;
        logic [4:0]  ia, rs, rt;
        logic [2:0]  rdy;
        logic        rsb, rtb;
        logic        wf;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic        wf;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    vec_t tbl[$];
    wr_t  sb[$];
    int   tests;
    int   fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic iv, input logic [4:0] ia, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [2:0] rdy, input logic rsb, input logic rtb,
                       input logic wf, input logic [4:0] wa, input logic [31:0] wd);
        vec_t r;
        r.v = v; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.iv = iv; r.ia = ia; r.rs = rs; r.rt = rt;
        r.rdy = rdy; r.rsb = rsb; r.rtb = rtb; r.wf = wf; r.wa = wa; r.wd = wd;
        tbl.push_back(r);
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        wr_t e;
        vec_t r;
        tests = 0;
        fails = 0;

        // Rows: valid, a0,a1,a2, d0,d1,d2, issue_v, issue_a, rs, rt | ready, rs_busy, rt_busy, wflag, wAddr, wrData
        add(3'b000,  0,  0,  0, 32'h0,         32'h0,         32'h0,         1,  5,  5,  0, 3'b000, 0, 0, 0,  0, 32'h0);
        add(3'b001,  5,  0,  0, 32'hDEADBEEF,  32'h0,         32'h0,         1,  7,  5,  7, 3'b001, 1, 0, 1,  5, 32'hDEADBEEF);
        add(3'b010,  0,  0,  0, 32'h0,         32'h12345678,  32'h0,         1,  0,  5,  0, 3'b010, 0, 0, 0,  0, 32'h12345678);
        add(3'b100,  0,  0,  7, 32'h0,         32'h0,         32'h00000777,  1,  7,  7,  0, 3'b100, 1, 0, 1,  7, 32'h00000777);
        add(3'b000,  0,  0,  0, 32'h0,         32'h0,         32'h0,         1, 10,  7,  5, 3'b000, 1, 0, 0,  7, 32'h00000777);
        add(3'b000,  0,  0,  0, 32'h0,         32'h0,         32'h0,         1, 11, 10,  0, 3'b000, 1, 0, 0,  7, 32'h00000777);
        add(3'b000,  0,  0,  0, 32'h0,         32'h0,         32'h0,         1, 12, 11, 12, 3'b000, 1, 0, 0,  7, 32'h00000777);
        add(3'b000,  0,  0,  0, 32'h0,         32'h0,         32'h0,         1, 13, 12, 13, 3'b000, 1, 0, 0,  7, 32'h00000777);
        add(3'b000,  0,  0,  0, 32'h0,         32'h0,         32'h0,         1, 14, 13, 14, 3'b000, 1, 0, 0,  7, 32'h00000777);
        add(3'b000,  0,  0,  0, 32'h0,         32'h0,         32'h0,         1, 15, 14, 15, 3'b000, 1, 0, 0,  7, 32'h00000777);
        add(3'b111, 10, 11, 12, 32'hA0A00000,  32'hB0B00000,  32'hC0C00000,  0,  0, 10, 15, 3'b001, 1, 1, 1, 10, 32'hA0A00000);
        add(3'b111, 13, 11, 12, 32'hA1A10001,  32'hB0B00000,  32'hC0C00000,  0,  0, 10, 11, 3'b010, 0, 1, 1, 11, 32'hB0B00000);
        add(3'b111, 13, 14, 12, 32'hA1A10001,  32'hB1B10001,  32'hC0C00000,  0,  0, 11, 12, 3'b100, 0, 1, 1, 12, 32'hC0C00000);
        add(3'b111, 13, 14, 15, 32'hA1A10001,  32'hB1B10001,  32'hC1C10001,  0,  0, 12, 13, 3'b001, 0, 1, 1, 13, 32'hA1A10001);
        add(3'b111, 13, 14, 15, 32'hA1A10001,  32'hB1B10001,  32'hC1C10001,  0,  0, 13, 14, 3'b010, 0, 1, 1, 14, 32'hB1B10001);
        add(3'b111, 13, 14, 15, 32'hA1A10001,  32'hB1B10001,  32'hC1C10001,  0,  0, 14, 15, 3'b100, 0, 1, 1, 15, 32'hC1C10001);
        add(3'b000,  0,  0,  0, 32'h0,         32'h0,         32'h0,         0,  0, 15,  0, 3'b000, 0, 0, 0, 15, 32'hC1C10001);

        // Reset with every requester asking
        rst_n       = 1'b0;
        idle_inputs();
        req_valid   = 3'b111;
        rs_addr     = 5'd5;
        rt_addr     = REG_ZERO;
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wflag", 32'(regWriteFlag), 32'h0);
        chk("rst_waddr", 32'(wAddr), 32'h0);
        chk("rst_wdata", wrData, 32'h0);
        chk("rst_rs_busy", 32'(rs_busy), 32'h0);
        chk("rst_rt_busy", 32'(rt_busy), 32'h0);
        chk("rst_err", 32'(err_wb), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        req_valid = '0;

        // Table-driven main sequence
        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            @(negedge clk);
            req_valid   = r.v;
            req_addr    = {r.a2, r.a1, r.a0};
            req_data    = {r.d2, r.d1, r.d0};
            issue_valid = r.iv;
            issue_addr  = r.ia;
            rs_addr     = r.rs;
            rt_addr     = r.rt;
            #1;
            chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(r.rdy));
            chk($sformatf("row%0d_rs_busy", i), 32'(rs_busy), 32'(r.rsb));
            chk($sformatf("row%0d_rt_busy", i), 32'(rt_busy), 32'(r.rtb));
            e.wf = r.wf; e.wa = r.wa; e.wd = r.wd;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL row%0d_sb: got empty queue expected entry", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("row%0d_wflag", i), 32'(regWriteFlag), 32'(e.wf));
                chk($sformatf("row%0d_waddr", i), 32'(wAddr), 32'(e.wa));
                chk($sformatf("row%0d_wdata", i), wrData, e.wd);
            end
            chk($sformatf("row%0d_err", i), 32'(err_wb), 32'h0);
        end

        // Writeback to $9 without a prior issue raises the sticky error
        @(negedge clk);
        idle_inputs();
        req_valid   = 3'b001;
        req_addr    = {5'd0, 5'd0, 5'd9};
        req_data    = {32'h0, 32'h0, 32'h99990009};
        issue_valid = 1'b1;
        issue_addr  = 5'd20;
        rs_addr     = 5'd20;
        #1;
        chk("err_pre_ready", 32'(req_ready), 32'h1);
        chk("err_pre", 32'(err_wb), 32'h0);
        @(posedge clk);
        #1;
        chk("err_set", 32'(err_wb), 32'h1);
        chk("err_wflag", 32'(regWriteFlag), 32'h1);
        chk("err_waddr", 32'(wAddr), 32'd9);

        // Asynchronous reset in the middle of a LOAD handshake
        @(negedge clk);
        idle_inputs();
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd20, 5'd0};
        req_data  = {32'h0, 32'h00002020, 32'h0};
        #1;
        chk("ar_pre_ready", 32'(req_ready), 32'h2);
        chk("ar_pre_busy", 32'(rs_busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_ready", 32'(req_ready), 32'h0);
        chk("ar_wflag", 32'(regWriteFlag), 32'h0);
        chk("ar_waddr", 32'(wAddr), 32'h0);
        chk("ar_wdata", wrData, 32'h0);
        chk("ar_err", 32'(err_wb), 32'h0);
        chk("ar_busy", 32'(rs_busy), 32'h0);
        @(posedge clk);
        #1;
        chk("ar_hold_wflag", 32'(regWriteFlag), 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_post_wflag", 32'(regWriteFlag), 32'h0);
        chk("ar_post_busy", 32'(rs_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
